simon_input: RTL and testbench
==============================

SIMON_INPUT -- requirements
Module: simon_input

Interface
REQ-001 Parameter DEB_CYCLES, default 3, SHALL be the number of consecutive equal synchronized samples needed to change a debounced button state (range 1..15).
REQ-002 clk  input  1  SHALL be the single 60 Hz system clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be asynchronous, active-low; 0 forces the reset state immediately.
REQ-004 buttons  input  4  SHALL be the raw, asynchronous, bouncing pushbuttons; bit i is colour/number i.
REQ-005 simonTurn  input  1  SHALL be 1 while the game engine is playing its sequence.
REQ-006 simonNum  input  2  SHALL be the number the game engine is currently showing.
REQ-007 simonPressed  input  1  SHALL be 1 while the game engine holds its shown number lit.
REQ-008 gameOver  input  1  SHALL be 1 once the game has ended.
REQ-009 playerNum  output  2  SHALL be the binary number of the last accepted player press.
REQ-010 playerPressed  output  1  SHALL be a single-cycle pulse marking acceptance of one player press.
REQ-011 leds  output  4  SHALL be the one-hot lamp drive shown to the player.
REQ-012 multiPress  output  1  SHALL be a single-cycle pulse when a chord (2+ buttons) is rejected.

Function
REQ-013 Each buttons bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 Per bit, a 4-bit debounce counter SHALL count consecutive synchronized samples differing from the debounced state, reset to 0 on any sample equal to it, and toggle the debounced state (counter cleared) on the edge where the count reaches DEB_CYCLES.
REQ-015 The block SHALL run a 4-state FSM: BLOCKED, WAIT_RELEASE, ARMED, HELD.
REQ-016 In any state, simonTurn=1 or gameOver=1 SHALL force BLOCKED on the next edge; no playerPressed or multiPress pulses while in or entering BLOCKED.
REQ-017 BLOCKED -> WAIT_RELEASE when simonTurn=0 and gameOver=0.
REQ-018 WAIT_RELEASE -> ARMED when the debounced vector is 0000; a button held across the turn change SHALL never be accepted.
REQ-019 ARMED with debounced vector exactly one-hot SHALL, on the same edge: load playerNum with the encoded index, pulse playerPressed for one cycle, enter HELD.
REQ-020 ARMED with 2+ debounced bits set SHALL pulse multiPress one cycle, leave playerNum unchanged, enter WAIT_RELEASE.
REQ-021 HELD -> ARMED when debounced vector is 0000; any additional bit rising in HELD SHALL be ignored (no pulse); a repeat of the same number requires full release.
REQ-022 Latency: a clean raw press held stable SHALL yield playerPressed exactly DEB_CYCLES+3 rising edges after the first edge sampling it high (2 sync + DEB_CYCLES debounce + 1 FSM).
REQ-023 leds SHALL equal onehot(simonNum) when simonTurn=1 and simonPressed=1; onehot(playerNum) in HELD; 0000 otherwise, including gameOver=1.
REQ-024 playerPressed and multiPress SHALL never be high in the same cycle, nor on two consecutive cycles.
REQ-025 Bounce shorter than DEB_CYCLES samples SHALL not change debounced state nor produce pulses.

Reset
REQ-026 During reset=0: state BLOCKED, synchronizers, debounced states and counters 0, playerNum=00, playerPressed=0, multiPress=0, leds=0000.
REQ-027 After reset release with simonTurn=0, gameOver=0, the FSM SHALL traverse WAIT_RELEASE before any acceptance.
REQ-028 Reset asserted mid-press SHALL abort the press; no pulse SHALL emerge after reset deasserts until buttons are released and re-pressed.

Verification
REQ-029 DEB_CYCLES=3, player turn, buttons=0100 held from cycle 10 -> playerPressed=1 only at cycle 16, playerNum=10, leds=0100 until release.
REQ-030 buttons bit0 toggling every cycle for 10 cycles then 0 -> no playerPressed, no multiPress, leds=0000.
REQ-031 buttons=0011 applied together in ARMED -> one multiPress pulse, playerNum unchanged, no playerPressed until 0000 then 0001 -> playerNum=00 pulse.
REQ-032 buttons=1000 held while simonTurn falls 1->0 -> no pulse; release then press 1000 -> one pulse, playerNum=11.
REQ-033 simonTurn=1, simonPressed=1, simonNum=01 -> leds=0010; buttons presses meanwhile -> no pulses.
REQ-034 reset=0 pulse at cycle 14 during a 0100 press -> all outputs cleared, no pulse after reset release while 0100 stays held.

Source files
------------

// File: rtl/simon_input.sv
// Player input front-end for a Simon game: synchronises and debounces four
// pushbuttons, then turns clean presses into single-cycle accept/chord pulses.
module simon_input #(
  parameter int unsigned DEB_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] buttons,
  input  logic       simonTurn,
  input  logic [1:0] simonNum,
  input  logic       simonPressed,
  input  logic       gameOver,
  output logic [1:0] playerNum,
  output logic       playerPressed,
  output logic [3:0] leds,
  output logic       multiPress
);

  localparam logic [3:0] DEB_LIM = 4'(DEB_CYCLES);

  typedef enum logic [1:0] {
    BLOCKED      = 2'd0,
    WAIT_RELEASE = 2'd1,
    ARMED        = 2'd2,
    HELD         = 2'd3
  } state_e;

  function automatic logic [3:0] onehot4(input logic [1:0] n);
    onehot4 = 4'b0001 << n;
  endfunction

  function automatic logic [1:0] encode4(input logic [3:0] v);
    case (v)
      4'b0001: encode4 = 2'd0;
      4'b0010: encode4 = 2'd1;
      4'b0100: encode4 = 2'd2;
      4'b1000: encode4 = 2'd3;
      default: encode4 = 2'd0;
    endcase
  endfunction

  function automatic logic [2:0] ones4(input logic [3:0] v);
    ones4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  logic [3:0] meta_q;
  logic [3:0] sync_q;
  logic [3:0] deb_q;
  logic [3:0] deb_d;
  logic [3:0] cnt_q [4];
  logic [3:0] cnt_d [4];
  logic       quiet_s;

  state_e     state_q;
  state_e     state_d;
  logic [1:0] player_num_q;
  logic [1:0] player_num_d;
  logic       player_pressed_q;
  logic       player_pressed_d;
  logic       multi_press_q;
  logic       multi_press_d;
  logic [3:0] leds_q;
  logic [3:0] leds_d;
  logic [2:0] deb_ones_s;

  // Per-bit debounce: a run of DEB_CYCLES samples disagreeing with the held state flips it.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      deb_d[i] = deb_q[i];
      cnt_d[i] = 4'd0;
      if (sync_q[i] != deb_q[i]) begin
        if ((cnt_q[i] + 4'd1) == DEB_LIM) begin
          deb_d[i] = ~deb_q[i];
          cnt_d[i] = 4'd0;
        end else begin
          cnt_d[i] = cnt_q[i] + 4'd1;
        end
      end else begin
        cnt_d[i] = 4'd0;
      end
    end
  end

  // Fully released means nothing pending anywhere in the input pipeline, so a
  // button still held through reset or a turn change cannot sneak past re-arming.
  always_comb begin
    quiet_s = (deb_q == 4'd0) && (sync_q == 4'd0) && (meta_q == 4'd0);
    for (int i = 0; i < 4; i++) begin
      if (cnt_q[i] != 4'd0) begin
        quiet_s = 1'b0;
      end else begin
        quiet_s = quiet_s;
      end
    end
  end

  assign deb_ones_s = ones4(deb_q);

  // Player-turn FSM next state and the values its registered outputs will take.
  always_comb begin
    state_d          = state_q;
    player_num_d     = player_num_q;
    player_pressed_d = 1'b0;
    multi_press_d    = 1'b0;
    if (simonTurn || gameOver) begin
      state_d = BLOCKED;
    end else begin
      case (state_q)
        BLOCKED: begin
          state_d = WAIT_RELEASE;
        end
        WAIT_RELEASE: begin
          if (quiet_s) begin
            state_d = ARMED;
          end else begin
            state_d = WAIT_RELEASE;
          end
        end
        ARMED: begin
          if (deb_ones_s == 3'd1) begin
            player_num_d     = encode4(deb_q);
            player_pressed_d = 1'b1;
            state_d          = HELD;
          end else if (deb_ones_s >= 3'd2) begin
            multi_press_d = 1'b1;
            state_d       = WAIT_RELEASE;
          end else begin
            state_d = ARMED;
          end
        end
        HELD: begin
          if (deb_q == 4'd0) begin
            state_d = ARMED;
          end else begin
            state_d = HELD;
          end
        end
        default: begin
          state_d = BLOCKED;
        end
      endcase
    end

    if (gameOver) begin
      leds_d = 4'b0000;
    end else if (simonTurn && simonPressed) begin
      leds_d = onehot4(simonNum);
    end else if (state_d == HELD) begin
      leds_d = onehot4(player_num_d);
    end else begin
      leds_d = 4'b0000;
    end
  end

  // Input synchroniser and debounce state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= 4'd0;
      sync_q <= 4'd0;
      deb_q  <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= 4'd0;
      end
    end else begin
      meta_q <= buttons;
      sync_q <= meta_q;
      deb_q  <= deb_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= BLOCKED;
      player_num_q     <= 2'd0;
      player_pressed_q <= 1'b0;
      multi_press_q    <= 1'b0;
      leds_q           <= 4'd0;
    end else begin
      state_q          <= state_d;
      player_num_q     <= player_num_d;
      player_pressed_q <= player_pressed_d;
      multi_press_q    <= multi_press_d;
      leds_q           <= leds_d;
    end
  end

  assign playerNum     = player_num_q;
  assign playerPressed = player_pressed_q;
  assign multiPress    = multi_press_q;
  assign leds          = leds_q;

endmodule

// File: tb/tb_simon_input.sv
// Directed scenarios plus randomized traffic for simon_input, checked every
// cycle against a behavioural model of the button/turn rules.
module tb_simon_input;
  localparam int DEB = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] buttons;
  logic       simonTurn;
  logic [1:0] simonNum;
  logic       simonPressed;
  logic       gameOver;
  logic [1:0] playerNum;
  logic       playerPressed;
  logic [3:0] leds;
  logic       multiPress;

  simon_input #(.DEB_CYCLES(DEB)) dut (
    .clk(clk), .reset(reset), .buttons(buttons), .simonTurn(simonTurn),
    .simonNum(simonNum), .simonPressed(simonPressed), .gameOver(gameOver),
    .playerNum(playerNum), .playerPressed(playerPressed), .leds(leds),
    .multiPress(multiPress)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int pp_seen  = 0;
  int mp_seen  = 0;
  logic prev_pulse = 1'b0;

  // Reference model: raw -> two-sample delay -> "stable for DEB samples" -> turn rules.
  localparam int M_BLOCK = 0, M_WAIT = 1, M_ARMED = 2, M_HELD = 3;
  logic [3:0] m_stage1, m_stage2, m_stable;
  int         m_run [4];
  int         m_mode;
  logic [1:0] m_pnum;
  logic       m_pp, m_mp;
  logic [3:0] m_leds;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_stage1 = 4'd0; m_stage2 = 4'd0; m_stable = 4'd0;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
    m_mode = M_BLOCK; m_pnum = 2'd0; m_pp = 1'b0; m_mp = 1'b0; m_leds = 4'd0;
  endtask

  task automatic model_edge();
    logic [3:0] stable_next;
    int         run_next [4];
    bit         idle;
    int         held_cnt;
    int         held_idx;
    logic [3:0] one;
    if (!reset) begin
      model_clear();
      return;
    end
    idle = (m_stable == 4'd0) && (m_stage2 == 4'd0) && (m_stage1 == 4'd0);
    stable_next = m_stable;
    held_cnt = 0;
    held_idx = 0;
    for (int i = 0; i < 4; i++) begin
      if (m_run[i] != 0) idle = 0;
      if (m_stable[i]) begin held_cnt++; held_idx = i; end
      if (m_stage2[i] != m_stable[i]) begin
        run_next[i] = m_run[i] + 1;
        if (run_next[i] >= DEB) begin stable_next[i] = ~m_stable[i]; run_next[i] = 0; end
      end else begin
        run_next[i] = 0;
      end
    end
    m_pp = 1'b0; m_mp = 1'b0;
    if (simonTurn || gameOver) m_mode = M_BLOCK;
    else if (m_mode == M_BLOCK) m_mode = M_WAIT;
    else if (m_mode == M_WAIT) begin
      if (idle) m_mode = M_ARMED;
    end else if (m_mode == M_ARMED) begin
      if (held_cnt == 1) begin m_pnum = 2'(held_idx); m_pp = 1'b1; m_mode = M_HELD; end
      else if (held_cnt >= 2) begin m_mp = 1'b1; m_mode = M_WAIT; end
    end else if (held_cnt == 0) m_mode = M_ARMED;
    m_stage2 = m_stage1;
    m_stage1 = buttons;
    m_stable = stable_next;
    for (int i = 0; i < 4; i++) m_run[i] = run_next[i];
    one = 4'b0001;
    if (gameOver) m_leds = 4'd0;
    else if (simonTurn && simonPressed) m_leds = one << simonNum;
    else if (m_mode == M_HELD) m_leds = one << m_pnum;
    else m_leds = 4'd0;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("playerNum", {2'b00, playerNum}, {2'b00, m_pnum});
    check("playerPressed", {3'b000, playerPressed}, {3'b000, m_pp});
    check("multiPress", {3'b000, multiPress}, {3'b000, m_mp});
    check("leds", leds, m_leds);
    check("pulse_overlap", {3'b000, playerPressed & multiPress}, 4'd0);
    check("pulse_back_to_back", {3'b000, prev_pulse & (playerPressed | multiPress)}, 4'd0);
    prev_pulse = playerPressed | multiPress;
    pp_seen += int'(playerPressed);
    mp_seen += int'(multiPress);
  endtask

  task automatic hold(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  int pp0, mp0;
  int r;

  initial begin
    reset = 1'b0; buttons = 4'd0; simonTurn = 1'b0; simonNum = 2'd0;
    simonPressed = 1'b0; gameOver = 1'b0;
    model_clear();
    #1;
    check("rst_playerNum", {2'b00, playerNum}, 4'd0);
    check("rst_playerPressed", {3'b000, playerPressed}, 4'd0);
    check("rst_multiPress", {3'b000, multiPress}, 4'd0);
    check("rst_leds", leds, 4'd0);
    hold(2);
    reset = 1'b1;
    hold(10);

    // Clean single press: pulse on the 6th sampling edge, lamp held until release.
    pp0 = pp_seen;
    buttons = 4'b0100;
    for (int k = 1; k <= DEB + 3; k++) begin
      step();
      check("lat_pulse", {3'b000, playerPressed}, (k == DEB + 3) ? 4'd1 : 4'd0);
    end
    check("lat_num", {2'b00, playerNum}, 4'd2);
    check("lat_leds", leds, 4'b0100);
    hold(5);
    check("held_leds", leds, 4'b0100);
    check("single_pulse", 4'(pp_seen - pp0), 4'd1);
    buttons = 4'b0000;
    hold(8);
    check("release_leds", leds, 4'b0000);

    // Fast bounce on bit0 never settles.
    pp0 = pp_seen; mp0 = mp_seen;
    for (int k = 0; k < 10; k++) begin
      buttons = {3'b000, k[0] ? 1'b0 : 1'b1};
      step();
    end
    buttons = 4'b0000;
    hold(8);
    check("bounce_pp", 4'(pp_seen - pp0), 4'd0);
    check("bounce_mp", 4'(mp_seen - mp0), 4'd0);
    check("bounce_leds", leds, 4'b0000);

    // Chord rejected, then a clean single press accepted.
    pp0 = pp_seen; mp0 = mp_seen;
    buttons = 4'b0011;
    hold(10);
    check("chord_mp", 4'(mp_seen - mp0), 4'd1);
    check("chord_pp", 4'(pp_seen - pp0), 4'd0);
    check("chord_num", {2'b00, playerNum}, 4'd2);
    buttons = 4'b0000;
    hold(8);
    buttons = 4'b0001;
    hold(8);
    check("after_chord_pp", 4'(pp_seen - pp0), 4'd1);
    check("after_chord_num", {2'b00, playerNum}, 4'd0);
    buttons = 4'b0000;
    hold(8);

    // Button held across the turn change is never accepted.
    pp0 = pp_seen; mp0 = mp_seen;
    simonTurn = 1'b1;
    buttons = 4'b1000;
    hold(10);
    simonTurn = 1'b0;
    hold(15);
    check("carry_pp", 4'(pp_seen - pp0), 4'd0);
    check("carry_mp", 4'(mp_seen - mp0), 4'd0);
    buttons = 4'b0000;
    hold(8);
    buttons = 4'b1000;
    hold(8);
    check("repress_pp", 4'(pp_seen - pp0), 4'd1);
    check("repress_num", {2'b00, playerNum}, 4'd3);
    buttons = 4'b0000;
    hold(8);

    // Simon showing a number: lamp follows Simon, player presses ignored.
    pp0 = pp_seen; mp0 = mp_seen;
    simonTurn = 1'b1; simonPressed = 1'b1; simonNum = 2'd1;
    hold(2);
    check("simon_leds", leds, 4'b0010);
    buttons = 4'b0100;
    hold(10);
    buttons = 4'b0110;
    hold(5);
    check("simon_leds_press", leds, 4'b0010);
    check("simon_pp", 4'(pp_seen - pp0), 4'd0);
    check("simon_mp", 4'(mp_seen - mp0), 4'd0);
    buttons = 4'b0000; simonPressed = 1'b0; simonTurn = 1'b0;
    hold(10);

    // Reset in the middle of a press aborts it for good.
    buttons = 4'b0100;
    hold(4);
    reset = 1'b0;
    #1;
    check("midrst_num", {2'b00, playerNum}, 4'd0);
    check("midrst_pp", {3'b000, playerPressed}, 4'd0);
    check("midrst_mp", {3'b000, multiPress}, 4'd0);
    check("midrst_leds", leds, 4'd0);
    step();
    reset = 1'b1;
    pp0 = pp_seen;
    hold(20);
    check("postrst_pp", 4'(pp_seen - pp0), 4'd0);
    buttons = 4'b0000;
    hold(8);
    buttons = 4'b0100;
    hold(8);
    check("postrst_repress", 4'(pp_seen - pp0), 4'd1);
    buttons = 4'b0000;
    hold(8);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      reset = 1'b1;
      r = int'($urandom_range(0, 99));
      if (r < 10) begin
        r = int'($urandom_range(0, 5));
        buttons = (r < 2) ? 4'd0 : (r < 5) ? (4'b0001 << $urandom_range(0, 3)) : 4'($urandom);
      end else if (r < 16) begin
        buttons[$urandom_range(0, 3)] ^= 1'b1;
      end
      if ($urandom_range(0, 59) == 0) simonTurn = ~simonTurn;
      if (gameOver) begin
        if ($urandom_range(0, 19) == 0) gameOver = 1'b0;
      end else if ($urandom_range(0, 299) == 0) gameOver = 1'b1;
      if ($urandom_range(0, 7) == 0) simonPressed = ~simonPressed;
      if ($urandom_range(0, 7) == 0) simonNum = 2'($urandom);
      if ($urandom_range(0, 399) == 0) reset = 1'b0;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
